// File: rtl/act_s2_bank.sv
// Multi-channel ACT-style select bank: per-channel runtime-configurable select gates feeding a
// four-way data mux, a valid-tagged output pipeline, and a serial config loader with commit/abort.
module act_s2_bank #(
  parameter int unsigned XLEN = 2,
  parameter int unsigned NCH  = 4,
  parameter int unsigned PIPE = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NCH*XLEN-1:0] d00,
  input  logic [NCH*XLEN-1:0] d01,
  input  logic [NCH*XLEN-1:0] d10,
  input  logic [NCH*XLEN-1:0] d11,
  input  logic [NCH-1:0]      a0,
  input  logic [NCH-1:0]      b0,
  input  logic [NCH-1:0]      a1,
  input  logic [NCH-1:0]      b1,
  input  logic                in_valid,
  input  logic                cfg_start,
  input  logic                cfg_valid,
  input  logic                cfg_bit,
  input  logic                cfg_abort,
  output logic [NCH*XLEN-1:0] out,
  output logic                out_valid,
  output logic                cfg_busy,
  output logic                cfg_done
);

  localparam int unsigned CfgW = 4 * NCH;
  localparam int unsigned CntW = $clog2(CfgW);
  localparam logic [CfgW-1:0] CfgRst = {NCH{4'b0100}};

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [CfgW-1:0]   shadow_q, shadow_d;
  logic [CfgW-1:0]   active_q, active_d;
  logic [CfgW-1:0]   shadow_shift;

  // Channel 0 bit 0 arrives first, so bits enter at the top and migrate down.
  assign shadow_shift = {cfg_bit, shadow_q[CfgW-1:1]};

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    shadow_d = shadow_q;
    active_d = active_q;
    cfg_busy = 1'b0;
    cfg_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cfg_start) begin
          state_d  = StShift;
          count_d  = '0;
          shadow_d = '0;
        end
      end
      StShift: begin
        cfg_busy = 1'b1;
        if (cfg_abort) begin
          state_d  = StIdle;
          count_d  = '0;
          shadow_d = '0;
        end else if (cfg_valid) begin
          shadow_d = shadow_shift;
          count_d  = count_q + CntW'(1);
          if (count_q == CntW'(CfgW - 1)) begin
            active_d = shadow_shift;
            count_d  = '0;
            state_d  = StDone;
          end
        end
      end
      StDone: begin
        cfg_done = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      count_q  <= '0;
      shadow_q <= '0;
      active_q <= CfgRst;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  function automatic logic gate_op(input logic [1:0] op, input logic a, input logic b);
    logic r;
    unique case (op)
      2'b00:   r = a & b;
      2'b01:   r = a | b;
      2'b10:   r = a ^ b;
      default: r = a;
    endcase
    return r;
  endfunction

  logic [NCH*XLEN-1:0] sel_data;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic s0, s1;
    assign s0 = gate_op(active_q[4*gi +: 2], a0[gi], b0[gi]);
    assign s1 = gate_op(active_q[4*gi+2 +: 2], a1[gi], b1[gi]);
    always_comb begin
      unique case ({s0, s1})
        2'b00:   sel_data[gi*XLEN +: XLEN] = d00[gi*XLEN +: XLEN];
        2'b01:   sel_data[gi*XLEN +: XLEN] = d01[gi*XLEN +: XLEN];
        2'b10:   sel_data[gi*XLEN +: XLEN] = d10[gi*XLEN +: XLEN];
        default: sel_data[gi*XLEN +: XLEN] = d11[gi*XLEN +: XLEN];
      endcase
    end
  end

  logic [PIPE-1:0]     vld_q;
  logic [NCH*XLEN-1:0] data_q [PIPE];

  // Valid always advances; data only loads behind a valid so out holds between results.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      for (int j = 0; j < PIPE; j++) data_q[j] <= '0;
    end else begin
      vld_q[0] <= in_valid;
      if (in_valid) data_q[0] <= sel_data;
      for (int j = 1; j < PIPE; j++) begin
        vld_q[j] <= vld_q[j-1];
        if (vld_q[j-1]) data_q[j] <= data_q[j-1];
      end
    end
  end

  assign out       = data_q[PIPE-1];
  assign out_valid = vld_q[PIPE-1];

endmodule

// File: tb/tb_act_s2_bank.sv
// Directed self-checking bench for act_s2_bank (NCH=4, XLEN=2, PIPE=2).
module tb_act_s2_bank;

  localparam int unsigned XLEN = 2;
  localparam int unsigned NCH  = 4;
  localparam int unsigned PIPE = 2;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic [NCH*XLEN-1:0] d00 = 8'h00, d01 = 8'h55, d10 = 8'hAA, d11 = 8'hFF;
  logic [NCH-1:0]      a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic                in_valid = 1'b0, cfg_start = 1'b0, cfg_valid = 1'b0;
  logic                cfg_bit = 1'b0, cfg_abort = 1'b0;
  logic [NCH*XLEN-1:0] out;
  logic                out_valid, cfg_busy, cfg_done;

  int checks   = 0;
  int failures = 0;

  act_s2_bank #(.XLEN(XLEN), .NCH(NCH), .PIPE(PIPE)) dut (
    .clock     (clock),
    .reset     (reset),
    .d00       (d00),
    .d01       (d01),
    .d10       (d10),
    .d11       (d11),
    .a0        (a0),
    .b0        (b0),
    .a1        (a1),
    .b1        (b1),
    .in_valid  (in_valid),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_bit   (cfg_bit),
    .cfg_abort (cfg_abort),
    .out       (out),
    .out_valid (out_valid),
    .cfg_busy  (cfg_busy),
    .cfg_done  (cfg_done)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic set_ops(input logic [3:0] va0, input logic [3:0] vb0,
                         input logic [3:0] va1, input logic [3:0] vb1);
    a0 = va0; b0 = vb0; a1 = va1; b1 = vb1;
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if (out !== 8'h00 || out_valid !== 1'b0 || cfg_busy !== 1'b0 || cfg_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_init got out=%h v=%b busy=%b done=%b want 00/0/0/0",
               out, out_valid, cfg_busy, cfg_done);
    end
    tick;
    #2 reset = 1'b0;
    // ch0: S0 = 1&1, S1 = 0|1 -> d11 = 3
    set_ops(4'b0001, 4'b0001, 4'b0000, 4'b0001);
    in_valid = 1'b1;
    tick;
    tick;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (out !== 8'h00 || out_valid !== 1'b0 || cfg_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_traffic got out=%h v=%b busy=%b want 00/0/0", out, out_valid,
               cfg_busy);
    end
    tick;
    checks++;
    if (out !== 8'h00 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_held got out=%h v=%b want 00/0", out, out_valid);
    end
    #2 reset = 1'b0;
    tick;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL latency_early got v=%b want 0", out_valid);
    end
    tick;
    checks++;
    if (out !== 8'h03 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL first_result got out=%h v=%b want 03/1", out, out_valid);
    end
    tick;
    checks++;
    if (out !== 8'h03 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL first_hold got out=%h v=%b want 03/0", out, out_valid);
    end
  endtask

  task automatic test_throughput;
    // ch1 operands all ones -> d11; ch0 walks through the four selections.
    logic [3:0] ta0 [5] = '{4'b0011, 4'b0010, 4'b0010, 4'b0011, 4'b0011};
    logic [3:0] tb0 [5] = '{4'b0011, 4'b0011, 4'b0010, 4'b0011, 4'b0011};
    logic [3:0] ta1 [5] = '{4'b0010, 4'b0011, 4'b0010, 4'b0011, 4'b0010};
    logic [3:0] tb1 [5] = '{4'b0010, 4'b0010, 4'b0010, 4'b0011, 4'b0010};
    logic [7:0] exp [5] = '{8'h0E, 8'h0D, 8'h0C, 8'h0F, 8'h0E};
    for (int i = 0; i < 5; i++) begin
      set_ops(ta0[i], tb0[i], ta1[i], tb1[i]);
      in_valid = 1'b1;
      tick;
      if (i > 0) begin
        checks++;
        if (out !== exp[i-1] || out_valid !== 1'b1) begin
          failures++;
          $display("FAIL stream_%0d got out=%h v=%b want %h/1", i - 1, out, out_valid, exp[i-1]);
        end
      end
    end
    in_valid = 1'b0;
    tick;
    checks++;
    if (out !== exp[4] || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL stream_4 got out=%h v=%b want %h/1", out, out_valid, exp[4]);
    end
    for (int k = 0; k < 2; k++) begin
      tick;
      checks++;
      if (out !== exp[4] || out_valid !== 1'b0) begin
        failures++;
        $display("FAIL stream_hold_%0d got out=%h v=%b want %h/0", k, out, out_valid, exp[4]);
      end
    end
  endtask

  task automatic test_abort;
    for (int r = 0; r < 2; r++) begin
      int nb;
      nb = (r == 0) ? 7 : 15;
      cfg_start = 1'b1;
      tick;
      cfg_start = 1'b0;
      for (int n = 0; n < nb; n++) begin
        cfg_valid = 1'b1;
        cfg_bit   = 1'b1;
        tick;
      end
      cfg_abort = 1'b1;
      tick;
      cfg_abort = 1'b0;
      cfg_valid = 1'b0;
      checks++;
      if (cfg_busy !== 1'b0 || cfg_done !== 1'b0) begin
        failures++;
        $display("FAIL abort_%0d_state got busy=%b done=%b want 0/0", nb, cfg_busy, cfg_done);
      end
      tick;
      checks++;
      if (cfg_done !== 1'b0) begin
        failures++;
        $display("FAIL abort_%0d_nodone got done=%b want 0", nb, cfg_done);
      end
      // Reset config: S0 = 1&0, S1 = 0|1 -> d01; a committed pass-a config would give d10.
      set_ops(4'b0001, 4'b0000, 4'b0000, 4'b0001);
      in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
      tick;
      checks++;
      if (out !== 8'h01) begin
        failures++;
        $display("FAIL abort_%0d_data got out=%h want 01", nb, out);
      end
    end
  endtask

  task automatic test_cfg_load;
    logic [15:0] w;
    int busy_cnt;
    w = 16'h444A;
    cfg_start = 1'b1;
    tick;
    cfg_start = 1'b0;
    busy_cnt = cfg_busy ? 1 : 0;
    for (int n = 0; n < 16; n++) begin
      cfg_valid = 1'b1;
      cfg_bit   = w[n];
      if (n == 15) begin
        // Sample on the commit edge must still see the reset config.
        set_ops(4'b0001, 4'b0001, 4'b0000, 4'b0001);
        in_valid = 1'b1;
      end
      tick;
      if (cfg_busy) busy_cnt++;
    end
    cfg_valid = 1'b0;
    checks++;
    if (busy_cnt != 16 || cfg_done !== 1'b1) begin
      failures++;
      $display("FAIL cfg_load_busy got busy_cycles=%0d done=%b want 16/1", busy_cnt, cfg_done);
    end
    tick;
    checks++;
    if (out !== 8'h03 || out_valid !== 1'b1 || cfg_done !== 1'b0) begin
      failures++;
      $display("FAIL commit_edge got out=%h v=%b done=%b want 03/1/0", out, out_valid, cfg_done);
    end
    set_ops(4'b0001, 4'b0000, 4'b0001, 4'b0001);
    tick;
    in_valid = 1'b0;
    checks++;
    if (out !== 8'h01 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL post_commit_xor got out=%h v=%b want 01/1", out, out_valid);
    end
    tick;
    checks++;
    if (out !== 8'h02 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL xor_select_d10 got out=%h v=%b want 02/1", out, out_valid);
    end
  endtask

  task automatic test_ignored_events;
    logic [15:0] w;
    w = 16'h444F;
    cfg_start = 1'b1;
    cfg_valid = 1'b1;
    cfg_bit   = 1'b1;
    tick;
    cfg_start = 1'b0;
    for (int n = 0; n < 16; n++) begin
      cfg_valid = 1'b1;
      cfg_bit   = w[n];
      cfg_start = (n == 5);
      tick;
      if (n == 14) begin
        checks++;
        if (cfg_busy !== 1'b1 || cfg_done !== 1'b0) begin
          failures++;
          $display("FAIL ignored_count got busy=%b done=%b after 15 bits want 1/0", cfg_busy,
                   cfg_done);
        end
      end
    end
    cfg_valid = 1'b0;
    cfg_start = 1'b0;
    checks++;
    if (cfg_done !== 1'b1) begin
      failures++;
      $display("FAIL ignored_commit got done=%b after 16 bits want 1", cfg_done);
    end
    // ch0 pass/pass -> d11; ch1 reset config with a0=1,b0=0,a1=1,b1=0 -> d01.
    set_ops(4'b0011, 4'b0001, 4'b0011, 4'b0000);
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    checks++;
    if (out !== 8'h07) begin
      failures++;
      $display("FAIL pass_config got out=%h want 07", out);
    end
  endtask

  task automatic test_reset_mid_shift;
    cfg_start = 1'b1;
    tick;
    cfg_start = 1'b0;
    for (int n = 0; n < 5; n++) begin
      cfg_valid = 1'b1;
      cfg_bit   = 1'b0;
      tick;
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (cfg_busy !== 1'b0 || out !== 8'h00) begin
      failures++;
      $display("FAIL async_reset_shift got busy=%b out=%h want 0/00", cfg_busy, out);
    end
    cfg_valid = 1'b0;
    #1 reset = 1'b0;
    // Reset config gives d01; the pre-reset pass config would give d10.
    set_ops(4'b0001, 4'b0000, 4'b0000, 4'b0001);
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    checks++;
    if (out !== 8'h01 || cfg_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_restores_cfg got out=%h busy=%b want 01/0", out, cfg_busy);
    end
  endtask

  initial begin
    test_reset;
    test_throughput;
    test_abort;
    test_cfg_load;
    test_ignored_events;
    test_reset_mid_shift;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
